// File: rtl/fsm_stim_pkg.sv
// Shared definitions for the FSM stimulus sequencer: state encoding and default widths.
package fsm_stim_pkg;

  localparam int unsigned DEF_LEN_MAX = 32;
  localparam int unsigned DEF_LEN_W   = 6;
  localparam int unsigned DEF_ST_W    = 3;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_e;

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/fsm_stim_sequencer_stim_shift_reg.sv
// Pattern shift register: parallel load, shift right on enable, exposes the LSB and the
// bit that becomes the LSB after the next shift.
module stim_shift_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  output logic             lsb,
  output logic             next_lsb
);

  logic [WIDTH-1:0] data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end else if (shift) begin
      data <= {1'b0, data[WIDTH-1:1]};
    end
  end

  assign lsb      = data[0];
  assign next_lsb = data[1];

endmodule

// File: rtl/fsm_stim_sequencer.sv
// Plays a serial bit pattern into the lab FSM x input, one bit per step_en tick,
// capturing y and the final state, with a start/busy/done handshake.
module fsm_stim_sequencer
  import fsm_stim_pkg::*;
#(
  parameter int unsigned LEN_MAX = DEF_LEN_MAX,
  parameter int unsigned LEN_W   = DEF_LEN_W,
  parameter int unsigned ST_W    = DEF_ST_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN_MAX-1:0] pattern,
  input  logic [LEN_W-1:0]   length,
  input  logic               step_en,
  output logic               fsm_x,
  input  logic               fsm_y,
  input  logic [ST_W-1:0]    fsm_state,
  output logic               busy,
  output logic               done,
  output logic [LEN_MAX-1:0] y_capture,
  output logic [LEN_W-1:0]   match_count,
  output logic [ST_W-1:0]    last_state
);

  seq_state_e       state;
  logic [LEN_W-1:0] index;
  logic [LEN_W-1:0] eff_len;
  logic             load;
  logic             shift;
  logic             last_step;
  logic             sr_lsb;
  logic             sr_next;

  assign load      = (state == SEQ_IDLE) && start && (length != '0);
  assign shift     = (state == SEQ_RUN) && step_en;
  assign last_step = shift && (index == eff_len - LEN_W'(1));

  stim_shift_reg #(
    .WIDTH (LEN_MAX)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (pattern),
    .shift     (shift),
    .lsb       (sr_lsb),
    .next_lsb  (sr_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SEQ_IDLE;
      fsm_x       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      y_capture   <= '0;
      match_count <= '0;
      last_state  <= '0;
      index       <= '0;
      eff_len     <= '0;
    end else begin
      unique case (state)
        SEQ_IDLE: begin
          if (load) begin
            eff_len     <= LEN_W'(clamp_len(32'(length), LEN_MAX));
            y_capture   <= '0;
            match_count <= '0;
            last_state  <= '0;
            index       <= '0;
            fsm_x       <= pattern[0];
            busy        <= 1'b1;
            state       <= SEQ_RUN;
          end
        end
        SEQ_RUN: begin
          if (shift) begin
            // y_capture is cleared on start, so OR-ing in the indexed bit is enough
            y_capture   <= y_capture | (LEN_MAX'(fsm_y) << index);
            match_count <= match_count + LEN_W'(fsm_y);
            index       <= index + LEN_W'(1);
            if (last_step) begin
              last_state <= fsm_state;
              fsm_x      <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              state      <= SEQ_DONE;
            end else begin
              fsm_x <= sr_next;
            end
          end else begin
            fsm_x <= sr_lsb;
          end
        end
        SEQ_DONE: begin
          done  <= 1'b0;
          state <= SEQ_IDLE;
        end
        default: begin
          fsm_x <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= SEQ_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fsm_stim_sequencer.md
Name: fsm_stim_sequencer

Overview:
Controller that sequences the lab FSM datapath (single-bit input x, single-bit output y, 3-bit state counter). It plays a programmed serial bit pattern into the FSM's x input, one bit per pacing tick. On each tick it captures the FSM's y output and state. It reports results through a start/busy/done handshake, replacing hand-written x stimulus with a reusable on-chip driver.

Parameters:
LEN_MAX, 32, maximum pattern length in bits. Also sets the width of pattern and y_capture.
LEN_W, 6, width of the length and match_count fields. Must hold LEN_MAX.
ST_W, 3, width of the FSM state bus (a, b, c bits).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a run. Sampled only in IDLE.
pattern  in  LEN_MAX  stimulus bits, played LSB first. Latched on an accepted start.
length  in  LEN_W  number of bits to play. Latched on an accepted start.
step_en  in  1  pacing tick. One pattern bit is consumed per high cycle in RUN.
fsm_x  out  1  drives the FSM x input
fsm_y  in  1  FSM y output
fsm_state  in  ST_W  FSM state counter {a,b,c}
busy  out  1  high in RUN
done  out  1  one-cycle pulse when a run completes
y_capture  out  LEN_MAX  captured y bits. Bit i holds y observed while pattern bit i was applied.
match_count  out  LEN_W  number of steps with fsm_y=1
last_state  out  ST_W  fsm_state sampled on the final step

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, fsm_x=0, busy=0, done=0, y_capture=0, match_count=0, last_state=0, internal shift register=0, index=0.
- Reset asserted mid-run aborts immediately to the reset values. No done pulse is produced.
- States: IDLE, RUN, DONE. Encoding comes from the shared package.
- IDLE:
  - start=1 and length!=0: latch pattern into the shift register; latch eff_len = min(length, LEN_MAX); clear y_capture, match_count, last_state and index; load fsm_x <= pattern[0]; next state RUN.
  - start=1 and length=0: start is ignored and the block stays in IDLE.
- RUN (busy=1):
  - fsm_x is registered and always equals the current shift-register LSB. It changes only on the clock edge after a step.
  - Cycle with step_en=1: y_capture[index] <= fsm_y; match_count += fsm_y; shift the register right by one; fsm_x <= next bit; index += 1.
  - If index == eff_len-1 on that step: also last_state <= fsm_state, fsm_x <= 0, next state DONE.
  - Cycle with step_en=0: all registers hold.
  - start is ignored while in RUN.
- DONE: done=1 for exactly one cycle and busy=0. Next state IDLE unconditionally. start in DONE is ignored.
- Result registers (y_capture, match_count, last_state) hold their values until the next accepted start.
- Latency:
  - First bit appears on fsm_x the cycle after start is accepted.
  - done asserts the cycle after the final step.
  - Minimum run with step_en tied high: eff_len+1 cycles from start to done.
- Width rules:
  - length values above LEN_MAX clamp to LEN_MAX.
  - match_count never exceeds LEN_MAX, so it cannot wrap.
  - index counts 0..eff_len-1 and never wraps.
- Simultaneous events: a step_en on the last step and a start in the same cycle means the start is ignored, because the FSM is not in IDLE.

Decomposition:
- Package fsm_stim_pkg:
  - state encoding constants SEQ_IDLE=2'd0, SEQ_RUN=2'd1, SEQ_DONE=2'd2
  - default LEN_MAX, LEN_W, ST_W
- One natural sub-module: stim_shift_reg. It holds the LEN_MAX-bit pattern with load, shift-right-on-enable and LSB output, and is reusable by future stimulus drivers.
- The control FSM, counters and capture logic stay in the top module.

Test Plan:
- Bench setup: an echo stub FSM (y=x, fsm_state=counter of steps) gives deterministic checks.
- Test 1: reset mid-run at step 3 of length 8 -> all outputs 0 immediately, no done pulse. A following start with pattern=0x5, length=3 completes normally: y_capture=0x5, match_count=2.
- Test 2: pattern=0x0000_0006, length=4, step_en=1 -> fsm_x sequence 0,1,1,0; y_capture=0x6; match_count=2; done 5 cycles after start; busy high for 4 cycles.
- Test 3: pattern=0xFFFF_FFFF, length=40 -> clamped to 32 steps; match_count=32; y_capture=0xFFFF_FFFF.
- Test 4: step_en toggled 1,0,0,1,0,1 with length=3, pattern=0x3 -> exactly 3 captures; fsm_x holds during idle ticks; done one cycle after the third tick.
- Test 5: start with length=0 -> stays IDLE, busy=0, no done. Start pulsed during RUN -> ignored, and the run completes unchanged.
- Test 6: real lab FSM attached, pattern 0b0110_1010_1101 LSB first, length=12 -> y_capture and last_state match the reference-model FSM, bit for bit.
